// File: rtl/data_axil_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : data_axil_bridge                                                 |
// | Brief   : CPU data-port to AXI4-Lite master bridge with load extension.    |
// |           Optional wait-state timeout when AXIL_TIMEOUT_EN is defined.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module data_axil_bridge #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic        req_we_i,
  input  logic        req_re_i,
  input  logic [2:0]  req_size_i,
  output logic        busy_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        err_o,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_wr      = 3'd1;
  localparam logic [2:0] c_wr_resp = 3'd2;
  localparam logic [2:0] c_rd_addr = 3'd3;
  localparam logic [2:0] c_rd_data = 3'd4;
  localparam logic [2:0] c_done    = 3'd5;

  logic [2:0]  r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_pend;
  logic        r_w_pend;
  logic [31:0] r_rsp_data;
  logic        r_err;

  logic        w_req;
  logic        w_legal;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic        w_wait;
  logic        w_aw_left;
  logic        w_w_left;
  logic        w_timeout;

  assign w_req     = req_we_i | req_re_i;
  assign w_wait    = (r_state == c_wr) | (r_state == c_wr_resp) |
                     (r_state == c_rd_addr) | (r_state == c_rd_data);
  assign w_aw_left = r_aw_pend & ~m_awready;
  assign w_w_left  = r_w_pend & ~m_wready;

  // Alignment and size legality are judged on the live request, before capture.
  always_comb begin
    case (req_size_i)
      3'b000, 3'b100: w_legal = 1'b1;
      3'b001, 3'b101: w_legal = ~req_addr_i[0];
      3'b010:         w_legal = (req_addr_i[1:0] == 2'b00);
      default:        w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_wdata = req_data_i;
    w_wstrb = 4'b1111;
    case (req_size_i[1:0])
      2'b00: begin
        w_wdata = {4{req_data_i[7:0]}};
        w_wstrb = 4'b0001 << req_addr_i[1:0];
      end
      2'b01: begin
        w_wdata = {2{req_data_i[15:0]}};
        w_wstrb = 4'b0011 << req_addr_i[1:0];
      end
      default: ;
    endcase
  end

  // Lane shift brings the addressed byte/half down to bit 0; word loads are aligned so shift is 0.
  assign w_shifted = m_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_size)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load = {24'h0, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load = {16'h0, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

`ifdef AXIL_TIMEOUT_EN
  localparam int c_cnt_raw = $clog2(TIMEOUT_CYC + 1);
  localparam int c_cnt_w   = (c_cnt_raw < 8) ? 8 : ((c_cnt_raw > 16) ? 16 : c_cnt_raw);
  localparam logic [c_cnt_w-1:0] c_cnt_lim = c_cnt_w'(TIMEOUT_CYC - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               w_any_hs;
  logic               w_advance;

  assign w_any_hs  = ((r_state == c_wr) & ((r_aw_pend & m_awready) | (r_w_pend & m_wready))) |
                     ((r_state == c_wr_resp) & m_bvalid) |
                     ((r_state == c_rd_addr) & m_arready) |
                     ((r_state == c_rd_data) & m_rvalid);
  assign w_advance = ((r_state == c_wr) & ~w_aw_left & ~w_w_left) |
                     ((r_state == c_wr_resp) & m_bvalid) |
                     ((r_state == c_rd_addr) & m_arready) |
                     ((r_state == c_rd_data) & m_rvalid);
  assign w_timeout = (r_cnt == c_cnt_lim) & ~w_any_hs;

  // Partial write handshakes hold the count; only idle cycles advance it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!w_wait || w_advance) begin
      r_cnt <= '0;
    end else if (!w_any_hs) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_idle;
      r_addr     <= '0;
      r_size     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_aw_pend  <= 1'b0;
      r_w_pend   <= 1'b0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_req) begin
            r_addr     <= req_addr_i;
            r_size     <= req_size_i;
            r_rsp_data <= '0;
            r_err      <= 1'b0;
            if (!w_legal) begin
              r_err   <= 1'b1;
              r_state <= c_done;
            end else if (req_we_i) begin
              r_wdata   <= w_wdata;
              r_wstrb   <= w_wstrb;
              r_aw_pend <= 1'b1;
              r_w_pend  <= 1'b1;
              r_state   <= c_wr;
            end else begin
              r_state <= c_rd_addr;
            end
          end
        end
        c_wr: begin
          r_aw_pend <= w_aw_left;
          r_w_pend  <= w_w_left;
          if (!w_aw_left && !w_w_left) begin
            r_state <= c_wr_resp;
          end else if (w_timeout) begin
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= c_done;
          end
        end
        c_wr_resp: begin
          if (m_bvalid) begin
            r_err   <= |m_bresp;
            r_state <= c_done;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= c_done;
          end
        end
        c_rd_addr: begin
          if (m_arready) begin
            r_state <= c_rd_data;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= c_done;
          end
        end
        c_rd_data: begin
          if (m_rvalid) begin
            r_rsp_data <= w_load;
            r_err      <= |m_rresp;
            r_state    <= c_done;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= c_done;
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  assign m_awaddr  = {r_addr[31:2], 2'b00};
  assign m_araddr  = {r_addr[31:2], 2'b00};
  assign m_awprot  = 3'b000;
  assign m_arprot  = 3'b000;
  assign m_awvalid = r_aw_pend;
  assign m_wvalid  = r_w_pend;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_bready  = (r_state == c_wr_resp);
  assign m_arvalid = (r_state == c_rd_addr);
  assign m_rready  = (r_state == c_rd_data);

  // The request term is combinational so the pipeline stalls in the acceptance cycle.
  assign busy_o      = rst & (((r_state == c_idle) & w_req) | w_wait);
  assign rsp_valid_o = (r_state == c_done);
  assign rsp_data_o  = rsp_valid_o ? r_rsp_data : 32'h0;
  assign err_o       = rsp_valid_o & r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_axil_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_data_axil_bridge                                              |
// | Brief   : Directed self-checking bench for data_axil_bridge.               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_data_axil_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_addr_i, req_data_i;
  logic        req_we_i, req_re_i;
  logic [2:0]  req_size_i;
  logic        busy_o, rsp_valid_o, err_o;
  logic [31:0] rsp_data_o;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  int checks = 0;
  int errors = 0;

  data_axil_bridge #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_we_i(req_we_i), .req_re_i(req_re_i), .req_size_i(req_size_i),
    .busy_o(busy_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .err_o(err_o),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Read with a slave that is ready at once: acceptance, RD_ADDR, RD_DATA, DONE.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] rdata, input logic [1:0] rresp,
                         input logic [31:0] exp_data, input logic exp_err);
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = rdata; m_rresp = rresp;
    req_re_i = 1'b1; req_addr_i = addr; req_size_i = size;
    step();
    req_re_i = 1'b0;
    chk({tag, "_arvalid"}, {31'h0, m_arvalid}, 32'h1);
    chk({tag, "_araddr"}, m_araddr, {addr[31:2], 2'b00});
    step();
    chk({tag, "_rready"}, {31'h0, m_rready}, 32'h1);
    step();
    chk({tag, "_rsp_valid"}, {31'h0, rsp_valid_o}, 32'h1);
    chk({tag, "_data"}, rsp_data_o, exp_data);
    chk({tag, "_err"}, {31'h0, err_o}, {31'h0, exp_err});
    m_rvalid = 1'b0; m_arready = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b0;
    req_addr_i = '0; req_data_i = '0; req_we_i = 1'b0; req_re_i = 1'b0; req_size_i = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;

    // Reset state, with a request pending that must not raise busy.
    req_we_i = 1'b1;
    #3;
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("rst_awvalid", {31'h0, m_awvalid}, 32'h0);
    chk("rst_arvalid", {31'h0, m_arvalid}, 32'h0);
    chk("rst_awaddr", m_awaddr, 32'h0);
    chk("rst_wstrb", {28'h0, m_wstrb}, 32'h0);
    chk("rst_rsp_data", rsp_data_o, 32'h0);
    req_we_i = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step();

    // Word write, slave ready at once.
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
    req_we_i = 1'b1; req_addr_i = 32'h0000_1000; req_data_i = 32'hDEAD_BEEF; req_size_i = 3'b010;
    #1;
    chk("sw_busy_idle", {31'h0, busy_o}, 32'h1);
    step();
    req_we_i = 1'b0;
    chk("sw_awvalid", {31'h0, m_awvalid}, 32'h1);
    chk("sw_wvalid", {31'h0, m_wvalid}, 32'h1);
    chk("sw_awaddr", m_awaddr, 32'h0000_1000);
    chk("sw_wstrb", {28'h0, m_wstrb}, 32'hF);
    chk("sw_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("sw_awprot", {29'h0, m_awprot}, 32'h0);
    chk("sw_rsp_c1", {31'h0, rsp_valid_o}, 32'h0);
    step();
    chk("sw_bready", {31'h0, m_bready}, 32'h1);
    chk("sw_awvalid_drop", {31'h0, m_awvalid}, 32'h0);
    chk("sw_rsp_c2", {31'h0, rsp_valid_o}, 32'h0);
    step();
    chk("sw_rsp_c3", {31'h0, rsp_valid_o}, 32'h1);
    chk("sw_err", {31'h0, err_o}, 32'h0);
    chk("sw_busy_done", {31'h0, busy_o}, 32'h0);
    step();
    chk("sw_rsp_pulse", {31'h0, rsp_valid_o}, 32'h0);

    // Byte write at lane 3.
    req_we_i = 1'b1; req_addr_i = 32'h0000_1003; req_data_i = 32'h0000_00A5; req_size_i = 3'b000;
    step();
    req_we_i = 1'b0;
    chk("sb_wdata", m_wdata, 32'hA5A5_A5A5);
    chk("sb_wstrb", {28'h0, m_wstrb}, 32'h8);
    chk("sb_awaddr", m_awaddr, 32'h0000_1000);
    step();
    step();
    chk("sb_rsp", {31'h0, rsp_valid_o}, 32'h1);
    step();

    // Half write at lane 2.
    req_we_i = 1'b1; req_addr_i = 32'h0000_1002; req_data_i = 32'h0000_BEEF; req_size_i = 3'b001;
    step();
    req_we_i = 1'b0;
    chk("sh_wdata", m_wdata, 32'hBEEF_BEEF);
    chk("sh_wstrb", {28'h0, m_wstrb}, 32'hC);
    step();
    step();
    step();
    m_bvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;

    // Loads with sign/zero extension.
    do_read("lb",  32'h0000_2002, 3'b000, 32'h12F0_5678, 2'b00, 32'hFFFF_FFF0, 1'b0);
    do_read("lhu", 32'h0000_2002, 3'b101, 32'h12F0_5678, 2'b00, 32'h0000_12F0, 1'b0);
    do_read("lh",  32'h0000_2000, 3'b001, 32'h1234_8001, 2'b00, 32'hFFFF_8001, 1'b0);
    do_read("lbu", 32'h0000_2003, 3'b100, 32'h9234_8001, 2'b00, 32'h0000_0092, 1'b0);
    do_read("lw_slverr", 32'h0000_2004, 3'b010, 32'hCAFE_F00D, 2'b10, 32'hCAFE_F00D, 1'b1);

    // Write with wready at once, awready four cycles later, SLVERR response.
    m_wready = 1'b1;
    req_we_i = 1'b1; req_addr_i = 32'h0000_1004; req_data_i = 32'h1122_3344; req_size_i = 3'b010;
    step();
    req_we_i = 1'b0;
    chk("slow_aw_both", {30'h0, m_awvalid, m_wvalid}, 32'h3);
    step();
    m_wready = 1'b0;
    chk("slow_aw_c1", {30'h0, m_awvalid, m_wvalid}, 32'h2);
    step();
    chk("slow_aw_c2", {30'h0, m_awvalid, m_wvalid}, 32'h2);
    step();
    chk("slow_aw_c3", {30'h0, m_awvalid, m_wvalid}, 32'h2);
    chk("slow_aw_busy", {31'h0, busy_o}, 32'h1);
    step();
    chk("slow_aw_c4", {30'h0, m_awvalid, m_wvalid}, 32'h2);
    chk("slow_aw_bready_lo", {31'h0, m_bready}, 32'h0);
    m_awready = 1'b1;
    step();
    m_awready = 1'b0;
    chk("slow_aw_done", {30'h0, m_awvalid, m_wvalid}, 32'h0);
    chk("slow_aw_bready", {31'h0, m_bready}, 32'h1);
    m_bvalid = 1'b1; m_bresp = 2'b10;
    step();
    m_bvalid = 1'b0; m_bresp = 2'b00;
    chk("slow_aw_rsp", {31'h0, rsp_valid_o}, 32'h1);
    chk("slow_aw_err", {31'h0, err_o}, 32'h1);
    step();

    // Misaligned word load: no bus traffic, one-cycle error.
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA;
    req_re_i = 1'b1; req_addr_i = 32'h0000_3001; req_size_i = 3'b010;
    step();
    req_re_i = 1'b0;
    chk("mis_arvalid", {31'h0, m_arvalid}, 32'h0);
    chk("mis_rsp", {31'h0, rsp_valid_o}, 32'h1);
    chk("mis_err", {31'h0, err_o}, 32'h1);
    chk("mis_data", rsp_data_o, 32'h0);
    step();
    chk("mis_rsp_pulse", {31'h0, rsp_valid_o}, 32'h0);
    m_arready = 1'b0; m_rvalid = 1'b0;

    // Misaligned half write and illegal size write.
    req_we_i = 1'b1; req_addr_i = 32'h0000_1001; req_size_i = 3'b001;
    step();
    req_we_i = 1'b0;
    chk("mis_h_awvalid", {31'h0, m_awvalid}, 32'h0);
    chk("mis_h_err", {31'h0, err_o}, 32'h1);
    step();
    req_we_i = 1'b1; req_addr_i = 32'h0000_1000; req_size_i = 3'b011;
    step();
    req_we_i = 1'b0;
    chk("ill_awvalid", {31'h0, m_awvalid}, 32'h0);
    chk("ill_rsp_err", {30'h0, rsp_valid_o, err_o}, 32'h3);
    step();

    // Simultaneous store and load: the store wins.
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    req_we_i = 1'b1; req_re_i = 1'b1; req_addr_i = 32'h0000_4000; req_size_i = 3'b010;
    step();
    req_we_i = 1'b0; req_re_i = 1'b0;
    chk("both_awvalid", {31'h0, m_awvalid}, 32'h1);
    chk("both_arvalid", {31'h0, m_arvalid}, 32'h0);
    step();
    step();
    chk("both_rsp", {30'h0, rsp_valid_o, err_o}, 32'h2);
    step();
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;

    // Reset asserted in RD_DATA aborts without a response pulse.
    m_arready = 1'b1;
    req_re_i = 1'b1; req_addr_i = 32'h0000_2000; req_size_i = 3'b010;
    step();
    req_re_i = 1'b0;
    step();
    chk("abort_rready", {31'h0, m_rready}, 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_rready_lo", {31'h0, m_rready}, 32'h0);
    chk("abort_busy", {31'h0, busy_o}, 32'h0);
    chk("abort_rsp", {31'h0, rsp_valid_o}, 32'h0);
    m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
    step();
    rst = 1'b1;
    step();
    chk("abort_no_rsp1", {31'h0, rsp_valid_o}, 32'h0);
    step();
    chk("abort_no_rsp2", {30'h0, rsp_valid_o, busy_o}, 32'h0);
    m_rvalid = 1'b0; m_arready = 1'b0;

`ifdef AXIL_TIMEOUT_EN
    // arready never comes: arvalid holds for 16 cycles, then an error response.
    req_re_i = 1'b1; req_addr_i = 32'h0000_5000; req_size_i = 3'b010;
    step();
    req_re_i = 1'b0;
    chk("to_arvalid_0", {31'h0, m_arvalid}, 32'h1);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("to_arvalid_hold", {31'h0, m_arvalid}, 32'h1);
    end
    step();
    chk("to_arvalid_drop", {31'h0, m_arvalid}, 32'h0);
    chk("to_rsp_err", {30'h0, rsp_valid_o, err_o}, 32'h3);
    chk("to_data", rsp_data_o, 32'h0);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
